dff_feed_fifo: RTL and testbench
================================

Name: dff_feed_fifo

Overview:
- Synchronous FIFO that buffers words from the stimulus/driver side.
- Presents one word per accepted pop on a registered output.
- rd_data drives the din input of the downstream parameterised D flip-flop stage, so both stages share one WIDTH.
- Same single clock domain as the dff; exposes occupancy and sticky error flags to the bench.

Parameters:
- WIDTH, 8, data word width in bits; must match the downstream dff WIDTH.
- DEPTH, 4, number of storage entries; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  push request.
- wr_data  input  WIDTH  push data.
- rd_en  input  1  pop request.
- rd_data  output  WIDTH  registered pop data; feeds dff din.
- rd_valid  output  1  high for exactly the cycle after an accepted pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set by a rejected push.
- underflow  output  1  sticky; set by a rejected pop.
- clr_err  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (asynchronous on rst rising, held while rst=1):
  - wr_ptr, rd_ptr, count = 0; empty=1; full=0.
  - rd_data = 0; rd_valid = 0; overflow = 0; underflow = 0.
  - Storage array contents are don't-care.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is a separate register and is the single source for full and empty, which are combinational from count.
- Pop accepted (do_rd) when rd_en && !empty, evaluated against pre-edge state.
- Push accepted (do_wr) when wr_en && (!full || do_rd). A push on a full FIFO is accepted only when a pop is accepted in the same cycle.
- Push on empty with simultaneous rd_en: the push is accepted and the pop is rejected. The written word is not bypassed; it is readable from the next cycle.
- On do_wr: mem[wr_ptr] <= wr_data; wr_ptr increments.
- On do_rd:
  - rd_data <= mem[rd_ptr]; rd_ptr increments.
  - rd_valid <= 1 on the next edge, otherwise 0.
  - Read latency is 1 cycle from the accepting edge.
- rd_data holds its last value when no pop is accepted.
- count update: +1 on do_wr only; -1 on do_rd only; unchanged on both or neither.
- overflow <= 1 when wr_en && !do_wr.
- underflow <= 1 when rd_en && !do_rd.
- clr_err=1 clears both flags on the edge. If clr_err is asserted in the same cycle as a new error, the set wins.
- Ordering is strict FIFO across any number of wrap-arounds.
- Reset mid-operation: all in-flight state is discarded immediately; the first push after rst deasserts lands at entry 0.
- No X propagation: outputs are defined in all cycles after reset.

Test Plan:
1. Reset then fill: rst=1 for 2 cycles, release, push 8'h11,8'h22,8'h33,8'h44 -> count 1,2,3,4; full=1 after the 4th push; empty=0; overflow=0.
2. Overflow: while full, push 8'h55 with rd_en=0 -> push rejected, overflow=1, count stays 4. Then drain 4 pops -> rd_data 11,22,33,44 in order, each with one-cycle rd_valid. Then empty=1.
3. Underflow and clear: pop when empty -> underflow=1, rd_valid=0, rd_data holds 8'h44. Pulse clr_err -> underflow=0 next cycle.
4. Simultaneous at full: fill with A0..A3, then wr_en=rd_en=1 with 8'hA4 -> rd_data=A0, count stays 4, no overflow. Drain -> A1,A2,A3,A4.
5. Wrap-around and empty-collision: 10 interleaved single push/pop pairs with data 8'h01..8'h0A -> outputs match in order, pointers wrap twice. Push on empty with rd_en=1 -> count=1, rd_valid=0, no bypass.
6. Reset mid-operation: with 3 entries held, assert rst asynchronously mid-cycle -> count=0, empty=1, rd_data=0 immediately. After release, push 8'hC3 and pop -> rd_data=8'hC3, which reaches the dff output one clock later.

Source files
------------

// File: rtl/dff_feed_fifo.sv
// Synchronous FIFO that feeds the downstream WIDTH-bit D flip-flop stage.
// It accepts pushes from the driver side and presents one word per accepted
// pop on a registered rd_data. Occupancy and sticky error flags are exposed.
module dff_feed_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // full and empty are derived only from count, never from pointer compares
  always_comb begin
    full  = (count == DEPTH_C);
    empty = (count == '0);
  end

  // Acceptance uses pre-edge state; a pop frees room for a push at full,
  // but a push on empty cannot be popped in the same cycle (no bypass).
  always_comb begin
    do_rd = rd_en && !empty;
    do_wr = wr_en && (!full || do_rd);
  end

  // Storage array; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH-1 because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy counter: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read port; rd_data holds its value between accepted pops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) rd_data <= mem[rd_ptr];
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !do_wr)      overflow <= 1'b1;
      else if (clr_err)         overflow <= 1'b0;
      if (rd_en && !do_rd)      underflow <= 1'b1;
      else if (clr_err)         underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dff_feed_fifo.sv
// Self-checking bench for dff_feed_fifo with a queue-based reference model
// and a scoreboard of expected pop data. A small register models the
// downstream dff stage fed by rd_data.
module tb_dff_feed_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic [WIDTH-1:0] dff_q;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sb[$];
  logic             m_ov = 1'b0;
  logic             m_un = 1'b0;
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_last = '0;

  dff_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // downstream dff stage fed by rd_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dff_q <= '0;
    else     dff_q <= rd_data;
  end

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    m_valid = 1'b0;
    m_last = '0;
  endtask

  // Apply one cycle of stimulus, step the model, sample #1 after the edge.
  task automatic drive(input logic we, input logic [WIDTH-1:0] wd,
                       input logic re, input logic ce);
    logic d_rd, d_wr;
    wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    d_rd = re && (mq.size() != 0);
    d_wr = we && ((mq.size() < DEPTH) || d_rd);
    if (d_rd) sb.push_back(mq.pop_front());
    if (d_wr) mq.push_back(wd);
    m_ov = (we && !d_wr) ? 1'b1 : (ce ? 1'b0 : m_ov);
    m_un = (re && !d_rd) ? 1'b1 : (ce ? 1'b0 : m_un);
    m_valid = d_rd;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_occupancy: count=%0d empty=%b full=%b, required 0/1/0",
               count, empty, full);
    end
    checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rd_data=%h rd_valid=%b ov=%b un=%b, required 00/0/0/0",
               rd_data, rd_valid, overflow, underflow);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      checks++;
      if (count !== CW'(i + 1) || full !== (i == 3) || empty !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d full=%b empty=%b ov=%b, required %0d/%b/0/0",
                 i, count, full, empty, overflow, i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [WIDTH-1:0] exp;
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== CW'(4) || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ov=%b count=%0d full=%b, required 1/4/1",
               overflow, count, full);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid_%0d: rd_valid=%b, required 1", i, rd_valid);
      end else begin
        exp = sb.pop_front();
        checks++;
        if (rd_data !== exp || rd_data !== vals[i]) begin
          errors++;
          $display("FAIL drain_data_%0d: rd_data=%h, required %h", i, rd_data, vals[i]);
        end
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL drain_end: rd_valid=%b empty=%b count=%0d, required 0/1/0",
               rd_valid, empty, count);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h44) begin
      errors++;
      $display("FAIL underflow_set: un=%b rd_valid=%b rd_data=%h, required 1/0/44",
               underflow, rd_valid, rd_data);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: un=%b ov=%b, required 0/0", underflow, overflow);
    end
    // error in the same cycle as clear: set wins
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (underflow !== m_un || underflow !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: un=%b, required 1", underflow);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] vals [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA0 || count !== CW'(4) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: rd_valid=%b rd_data=%h count=%0d ov=%b, required 1/a0/4/0",
               rd_valid, rd_data, count, overflow);
    end
    if (sb.size() != 0) exp = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rd_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL simul_drain_valid_%0d: rd_valid=%b, required 1", i, rd_valid);
      end else begin
        exp = sb.pop_front();
        checks++;
        if (rd_data !== exp || rd_data !== vals[i]) begin
          errors++;
          $display("FAIL simul_drain_%0d: rd_data=%h, required %h", i, rd_data, vals[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_collision();
    logic [WIDTH-1:0] exp;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rd_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL wrap_valid_%0d: rd_valid=%b, required 1", i, rd_valid);
      end else begin
        exp = sb.pop_front();
        checks++;
        if (rd_data !== exp || rd_data !== 8'(i)) begin
          errors++;
          $display("FAIL wrap_data_%0d: rd_data=%h, required %h", i, rd_data, 8'(i));
        end
      end
    end
    // push on empty with a pop request: push wins, no bypass
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    checks++;
    if (count !== CW'(1) || rd_valid !== 1'b0 || rd_data !== 8'h0A || underflow !== 1'b1) begin
      errors++;
      $display("FAIL empty_collision: count=%0d rd_valid=%b rd_data=%h un=%b, required 1/0/0a/1",
               count, rd_valid, rd_data, underflow);
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A || underflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL collision_readback: rd_valid=%b rd_data=%h un=%b empty=%b, required 1/5a/0/1",
               rd_valid, rd_data, underflow, empty);
    end
    if (sb.size() != 0) exp = sb.pop_front();
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] exp;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);  // leaves 2 held, rd_data nonzero
    drive(1'b1, 8'hB3, 1'b0, 1'b0);  // 3 held
    #3 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (count !== '0 || empty !== 1'b1 || rd_data !== '0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b rd_data=%h rd_valid=%b, required 0/1/00/0",
               count, empty, rd_data, rd_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    checks++;
    if (count !== CW'(1)) begin
      errors++;
      $display("FAIL post_reset_push: count=%0d, required 1", count);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL post_reset_valid: rd_valid=%b, required 1", rd_valid);
    end else begin
      exp = sb.pop_front();
      checks++;
      if (rd_data !== exp || rd_data !== 8'hC3) begin
        errors++;
        $display("FAIL post_reset_data: rd_data=%h, required c3", rd_data);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (dff_q !== 8'hC3 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL dff_stage: dff_q=%h rd_valid=%b, required c3/0", dff_q, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
